// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types, counter encodings and the 2-bit saturating
//               counter update for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t SNT = 2'b00;
    localparam bp_ctr_t WNT = 2'b01;
    localparam bp_ctr_t WT  = 2'b10;
    localparam bp_ctr_t ST  = 2'b11;

    function automatic bp_ctr_t sat_update(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_btb_ram.sv
`default_nettype none
// ============================================================================
// Module      : bp_btb_ram
// Description : Direct-mapped BTB storage (valid/tag/target). Asynchronous
//               fetch read with hit compare, tag probe for the training side,
//               synchronous write.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_btb_ram
    import bp_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int TAG_W   = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_hit,
    output logic [31:0]       rd_target,
    input  logic [IDX_W-1:0]  probe_idx,
    input  logic [TAG_W-1:0]  probe_tag,
    output logic              probe_hit,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [31:0]       wr_target
);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    assign rd_hit    = r_valid[rd_idx] && (r_tag[rd_idx] == rd_tag);
    assign rd_target = r_target[rd_idx];
    assign probe_hit = r_valid[probe_idx] && (r_tag[probe_idx] == probe_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset: they are only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx]    <= wr_tag;
            r_target[wr_idx] <= wr_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_btb
// Description : Dynamic branch predictor: direct-mapped BTB plus 2-bit
//               saturating counters, mispredict flush/redirect and a
//               saturating mispredict counter. Define BP_GSHARE_EN to index
//               the counter table with pc index XOR global history.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int TAG_W   = 8,
    parameter int HIST_W  = 5,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_f,
    output logic             pred_taken_f,
    output logic [31:0]      pred_pc_f,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_pc,
    output logic             flush_bp,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic [IDX_W-1:0] w_f_cidx;
    logic [IDX_W-1:0] w_u_cidx;
    logic             w_f_hit;
    logic [31:0]      w_f_target;
    logic             w_u_hit;
    logic             w_upd_en;
    logic             w_flush;

    bp_ctr_t          r_ctr [ENTRIES];
    logic [CNT_W-1:0] r_mispred_cnt;

    assign w_f_idx  = pc_f[IDX_W+1:2];
    assign w_f_tag  = pc_f[IDX_W+2 +: TAG_W];
    assign w_u_idx  = upd_pc[IDX_W+1:2];
    assign w_u_tag  = upd_pc[IDX_W+2 +: TAG_W];
    assign w_upd_en = upd_valid && !reset;

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] r_ghr;
    logic [IDX_W-1:0]  w_hist;

    // History occupies the top bits of the index; low bits are zero-padded.
    assign w_hist   = IDX_W'(r_ghr) << (IDX_W - HIST_W);
    assign w_f_cidx = w_f_idx ^ w_hist;
    assign w_u_cidx = w_u_idx ^ w_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (upd_valid) begin
            r_ghr <= {r_ghr[HIST_W-2:0], upd_taken};
        end
    end
`else
    assign w_f_cidx = w_f_idx;
    assign w_u_cidx = w_u_idx;
`endif

    bp_btb_ram #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (w_f_idx),
        .rd_tag    (w_f_tag),
        .rd_hit    (w_f_hit),
        .rd_target (w_f_target),
        .probe_idx (w_u_idx),
        .probe_tag (w_u_tag),
        .probe_hit (w_u_hit),
        .wr_en     (w_upd_en && upd_taken),
        .wr_idx    (w_u_idx),
        .wr_tag    (w_u_tag),
        .wr_target (upd_target)
    );

    assign pred_taken_f = w_f_hit && r_ctr[w_f_cidx][1];
    assign pred_pc_f    = pred_taken_f ? w_f_target : pc_f + 32'd4;

    assign w_flush = w_upd_en &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_target != upd_pred_pc)));

    assign flush_bp    = w_flush;
    assign redirect_pc = !w_flush  ? 32'd0      :
                         upd_taken ? upd_target : upd_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= WNT;
            end
        end else if (upd_valid) begin
            if (w_u_hit) begin
                r_ctr[w_u_cidx] <= sat_update(r_ctr[w_u_cidx], upd_taken);
            end else if (upd_taken) begin
                r_ctr[w_u_cidx] <= WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mispred_cnt <= '0;
        end else if (w_flush && !(&r_mispred_cnt)) begin
            r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire
